error_cal: RTL and testbench



---
 rtl/error_cal_pkg.sv | 25 ++
 rtl/error_cal_red.sv | 34 +++
 rtl/error_cal.sv | 71 +++++++
 tb/tb_error_cal.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/error_cal_pkg.sv
// Shared constants and types for the divider error-measurement block.
// Fixed-point formats: mantissas and reciprocal Q1.23, product Q2.46, RED Q0.32.
package error_cal_pkg;

    localparam int MANT_W    = 24;
    localparam int FRAC_W    = 23;
    localparam int RED_SHIFT = 14;

    localparam logic [7:0]        EXP_MIN = 8'd1;
    localparam logic [7:0]        EXP_MAX = 8'd254;
    localparam logic [MANT_W-1:0] R_C0    = 24'hC00000;
    localparam logic [47:0]       ONE_Q46 = 48'h4000_0000_0000;

    // One RED sample travelling down the pipeline
    typedef struct packed {
        logic        vld;
        logic [31:0] red;
    } red_s;

    // Normal operands only: zero, subnormal, Inf and NaN are rejected
    function automatic logic exp_ok(input logic [7:0] e);
        return (e >= EXP_MIN) && (e <= EXP_MAX);
    endfunction

endpackage

// File: rtl/error_cal_red.sv
// Combinational relative-error-distance of the linear reciprocal approximation.
// RED = |mb * (1.5 - mb/2) - 1|; it depends only on the divisor mantissa.
module red_unit
    import error_cal_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [31:0]     o_red,
    output logic            o_valid
);

    logic [MANT_W-1:0] w_mb;
    logic [MANT_W-1:0] w_r;
    logic [47:0]       w_p;
    logic [45:0]       w_d;
    logic              w_unused;

    assign o_valid = exp_ok(i_a[30:23]) && exp_ok(i_b[30:23]);

    assign w_mb = {1'b1, i_b[FRAC_W-1:0]};
    assign w_r  = R_C0 - (w_mb >> 1);
    assign w_p  = 48'(w_mb) * 48'(w_r);

    // |p - 1| never reaches 2^46, so 46 bits hold the difference exactly
    assign w_d = (w_p >= ONE_Q46) ? 46'(w_p - ONE_Q46) : 46'(ONE_Q46 - w_p);

    assign o_red = w_d[RED_SHIFT +: 32];

    // Signs and the dividend mantissa cancel out of the relative error
    assign w_unused = &{1'b0, i_a[31], i_a[FRAC_W-1:0], i_b[31]};

endmodule

// File: rtl/error_cal.sv
// Pipelined MRED monitor: register operands, register RED, then average RED
// over windows of 2^LOG2_WIN valid samples and publish the truncated mean.
module error_cal
    import error_cal_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LOG2_WIN = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [31:0]     MRED
);

    localparam int ACC_W = 32 + LOG2_WIN;

    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic                r_s0_vld;
    red_s                r_s1;
    logic [LOG2_WIN-1:0] r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [31:0]         r_mred;

    logic [31:0]         w_red;
    logic                w_red_vld;
    logic [ACC_W-1:0]    w_sum;
    logic                w_last;

    red_unit #(.XLEN(XLEN)) u_red (
        .i_a     (r_a),
        .i_b     (r_b),
        .o_red   (w_red),
        .o_valid (w_red_vld)
    );

    assign w_sum  = r_acc + {{LOG2_WIN{1'b0}}, r_s1.red};
    assign w_last = &r_cnt;
    assign MRED   = r_mred;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_s0_vld <= 1'b0;
            r_s1     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mred   <= '0;
        end else begin
            r_a      <= A;
            r_b      <= B;
            r_s0_vld <= 1'b1;
            r_s1.vld <= r_s0_vld & w_red_vld;
            r_s1.red <= w_red;
            // Invalid samples are bubbles: accumulator and counter hold
            if (r_s1.vld) begin
                if (w_last) begin
                    r_mred <= w_sum[ACC_W-1:LOG2_WIN];
                    r_acc  <= '0;
                    r_cnt  <= '0;
                end else begin
                    r_acc  <= w_sum;
                    r_cnt  <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_error_cal.sv
// Directed and random checks of error_cal against a cycle-level MRED model.
module tb_error_cal;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] MRED;

    error_cal #(.XLEN(32), .LOG2_WIN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MRED  (MRED)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int unsigned due_q[$];
    logic [31:0] exp_mred = '0;
    longint unsigned m_acc = 0;
    int          m_cnt = 0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    localparam logic [31:0] F_1P5  = 32'h3FC00000;
    localparam logic [31:0] F_1P25 = 32'h3FA00000;
    localparam logic [31:0] F_1P0  = 32'h3F800000;
    localparam logic [31:0] F_4P0  = 32'h40800000;

    function automatic logic is_normal(input logic [31:0] f);
        return (f[30:23] != 8'd0) && (f[30:23] != 8'd255);
    endfunction

    function automatic logic [31:0] ref_red(input logic [31:0] b);
        longint unsigned mb, r, p, d, one;
        one = 64'd1 << 46;
        mb  = 64'h800000 + 64'(b[22:0]);
        r   = 64'hC00000 - (mb >> 1);
        p   = mb * r;
        d   = (p >= one) ? (p - one) : (one - p);
        return 32'(d >> 14);
    endfunction

    function automatic logic [31:0] rand_normal();
        logic [31:0] f;
        f[31]    = 1'($urandom_range(0, 1));
        f[30:23] = 8'($urandom_range(1, 254));
        f[22:0]  = 23'($urandom);
        return f;
    endfunction

    // One clock: drive on the falling edge, model the rising edge, check 1 ns after
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic rst);
        logic [31:0] red;
        @(negedge clk);
        A     = a;
        B     = b;
        reset = rst;
        if (rst) begin
            exp_q.delete();
            due_q.delete();
            m_acc = 0;
            m_cnt = 0;
        end else if (is_normal(a) && is_normal(b)) begin
            red = ref_red(b);
            if (m_cnt == 15) begin
                exp_q.push_back(32'((m_acc + 64'(red)) >> 4));
                due_q.push_back(cyc + 3);
                m_acc = 0;
                m_cnt = 0;
            end else begin
                m_acc = m_acc + 64'(red);
                m_cnt = m_cnt + 1;
            end
        end
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (rst) exp_mred = '0;
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            exp_mred = exp_q.pop_front();
            void'(due_q.pop_front());
        end
        n_checks++;
        assert (MRED === exp_mred) else begin
            n_fail++;
            $error("FAIL mred cyc=%0d observed=%h expected=%h", cyc, MRED, exp_mred);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, F_1P5, 1'b0);
    endtask

    initial begin
        logic [31:0] inv_a[3];
        logic [31:0] inv_b[3];
        logic [31:0] ra, rb;
        inv_a = '{32'h00000000, F_4P0, F_4P0};
        inv_b = '{F_1P5, 32'h7F800000, 32'h00400000};

        // Reset held with valid-looking operands
        for (int i = 0; i < 3; i++) step(F_1P5, F_1P5, 1'b1);

        // Maximum RED window
        for (int i = 0; i < 16; i++) step(F_4P0, F_1P5, 1'b0);
        idle(3);
        n_checks++;
        assert (MRED === 32'h20000000) else begin
            n_fail++;
            $error("FAIL max_window observed=%h expected=%h", MRED, 32'h20000000);
        end

        // Exact reciprocal: zero error for any dividend
        for (int i = 0; i < 16; i++) step(rand_normal(), F_1P0, 1'b0);
        idle(3);

        // Half window at 1.5, half at 1.25
        for (int i = 0; i < 8; i++) step(F_4P0, F_1P5, 1'b0);
        for (int i = 0; i < 8; i++) step(F_4P0, F_1P25, 1'b0);
        idle(3);
        n_checks++;
        assert (MRED === 32'h1C000000) else begin
            n_fail++;
            $error("FAIL mixed_window observed=%h expected=%h", MRED, 32'h1C000000);
        end

        // Valid samples interleaved with zero / Inf / subnormal operands
        for (int i = 0; i < 16; i++) begin
            step(F_4P0, F_1P5, 1'b0);
            step(inv_a[i % 3], inv_b[i % 3], 1'b0);
        end
        idle(3);

        // Partial window discarded by a one-cycle reset
        for (int i = 0; i < 10; i++) step(F_4P0, F_1P25, 1'b0);
        step(F_4P0, F_1P25, 1'b1);
        for (int i = 0; i < 16; i++) step(F_4P0, F_1P25, 1'b0);
        idle(3);

        // Reset lands on the edge the window would complete
        for (int i = 0; i < 16; i++) step(F_4P0, F_1P5, 1'b0);
        idle(1);
        step(F_4P0, F_1P5, 1'b1);
        idle(3);

        // Random streams, occasionally non-normal
        for (int i = 0; i < 400; i++) begin
            ra = rand_normal();
            rb = rand_normal();
            if ($urandom_range(0, 15) == 0) ra[30:23] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
            if ($urandom_range(0, 15) == 0) rb[30:23] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
            step(ra, rb, 1'b0);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
